mem_word_bank: RTL and testbench
================================

# mem_word_bank

Parametrised successor to the single 32-bit byte-loaded memory register. Holds NUM_WORDS words of WORD_BYTES bytes, loaded one byte per cycle over the 8-bit input bus. Supports the existing addressed byte-load mode plus a streaming mode with an auto-incrementing byte pointer, word-complete pulse, full flag and sticky overflow flag. Sits between the 8-bit pad input path and downstream logic that consumes whole words.

## Interface

- WORD_BYTES, 4: bytes per word; word width is WORD_BYTES*8.
- NUM_WORDS, 4: number of words; at least 1, need not be a power of two.
- AW, derived: word-index width, max(1, clog2(NUM_WORDS)).
- BW, derived: byte-index width, max(1, clog2(WORD_BYTES)).
- PW, derived: pointer width, clog2(NUM_WORDS*WORD_BYTES + 1).

- clk  in  1  single clock; all state changes on the rising edge.
- rst_MEM_n  in  1  asynchronous reset, active-low.
- MEM_LOAD  in  1  byte write strobe, one byte per cycle while high.
- MEM_IN  in  8  byte to write.
- MEM_MODE  in  1  0 = addressed, 1 = stream.
- MEM_WADDR  in  AW  target word in addressed mode.
- MEM_LOAD_VAL  in  BW  target byte lane in addressed mode (0 = bits 7:0).
- MEM_CLR  in  1  synchronous clear of storage, pointer and flags.
- MEM_RSEL  in  AW  word selected onto MEM_OUT.
- MEM_OUT  out  WORD_BYTES*8  selected word, combinational from storage.
- MEM_PTR  out  PW  stream pointer (next byte to be written, linear index).
- MEM_WORD_DONE  out  1  one-cycle pulse when a stream write completes a word.
- MEM_FULL  out  1  stream pointer equals NUM_WORDS*WORD_BYTES.
- MEM_OVF  out  1  sticky: stream write attempted while full.

## Operation

- Reset (rst_MEM_n low, asynchronous): all storage 0, MEM_PTR 0, MEM_WORD_DONE 0, MEM_FULL 0, MEM_OVF 0.
- MEM_CLR high at edge: same effect as reset; overrides MEM_LOAD in that cycle.
- Addressed mode (MEM_MODE=0), MEM_LOAD=1: byte MEM_LOAD_VAL of word MEM_WADDR <= MEM_IN; other bytes unchanged. MEM_PTR, MEM_FULL, MEM_OVF unchanged. MEM_WADDR >= NUM_WORDS or MEM_LOAD_VAL >= WORD_BYTES: write ignored, no flag.
- Stream mode (MEM_MODE=1), MEM_LOAD=1, not full: byte at linear index MEM_PTR (word = PTR / WORD_BYTES, lane = PTR mod WORD_BYTES, lane 0 first) <= MEM_IN; MEM_PTR increments by 1.
- Stream write into lane WORD_BYTES-1: MEM_WORD_DONE high for the following cycle only.
- MEM_PTR reaching NUM_WORDS*WORD_BYTES: MEM_FULL high; no wrap. Stream writes while full: storage untouched, MEM_PTR unchanged, MEM_OVF set and held until reset/MEM_CLR.
- Mode switches mid-word retain MEM_PTR; addressed writes may overwrite already-streamed bytes.
- MEM_RSEL >= NUM_WORDS: MEM_OUT = 0.

## Timing

- Write latency: byte visible on MEM_OUT immediately after the capturing rising edge (same-cycle combinational read of stored value, no bypass of MEM_IN).
- MEM_PTR, MEM_FULL, MEM_OVF, MEM_WORD_DONE are registered; all update at the write edge.
- Back-to-back MEM_LOAD every cycle is supported in both modes; no handshake back-pressure, MEM_FULL is advisory.
- MEM_WORD_DONE never asserts in addressed mode or on an ignored (full) write.
- Reset asserted mid-stream: all outputs go to reset values without waiting for clk; release is taken synchronously by the design's reset synchroniser upstream.

## Structure

- Shared package mem_pkg: MODE_ADDR = 1'b0, MODE_STREAM = 1'b1 constants, clog2 helper function.
- Sub-module mem_byte_word: one WORD_BYTES-wide word with async active-low reset, sync clear, byte-lane write enable and 8-bit data; instantiated NUM_WORDS times via generate.
- Top: pointer/flag logic, address decode, output mux.

## Test plan

- Reset, then addressed writes AA/FF/CC/DD to lanes 0..3 of word 2 (defaults) -> MEM_RSEL=2 gives MEM_OUT=DDCCFFAA; other words 0; MEM_PTR=0.
- Stream 16 bytes 01..10 every cycle -> MEM_WORD_DONE pulses after bytes 4, 8, 12, 16; word 0 = 04030201, word 3 = 100F0E0D; MEM_FULL=1, MEM_PTR=16.
- While full, stream write EE -> storage unchanged, MEM_OVF=1 and held; MEM_CLR -> all zero, MEM_PTR=0, MEM_OVF=0, MEM_FULL=0.
- Stream 2 bytes 11,22, switch to addressed and write 99 to word 0 lane 3, back to stream writing 33 -> word 0 = 99332211, MEM_PTR=3, no MEM_WORD_DONE yet.
- MEM_CLR and MEM_LOAD in same cycle -> clear wins; out-of-range MEM_WADDR (NUM_WORDS=3 build, WADDR=3) -> write ignored, MEM_RSEL=3 gives 0.
- Assert rst_MEM_n low between clock edges mid-stream -> outputs zero immediately, before next rising edge.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and helpers for the byte-loaded word bank.
package mem_pkg;

  localparam logic MODE_ADDR   = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_byte_word.sv
// One storage word with independently writable byte lanes.
module mem_byte_word #(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [WORD_BYTES-1:0]     we,
  input  logic [7:0]                din,
  output logic [WORD_BYTES*8-1:0]   q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      for (int l = 0; l < int'(WORD_BYTES); l++) begin
        if (we[l]) q[l*8 +: 8] <= din;
      end
    end
  end

endmodule

// File: rtl/mem_word_bank.sv
// Bank of byte-loaded words: addressed byte writes plus an auto-incrementing stream pointer.
module mem_word_bank
  import mem_pkg::*;
#(
  parameter  int unsigned WORD_BYTES = 4,
  parameter  int unsigned NUM_WORDS  = 4,
  localparam int unsigned AW = (NUM_WORDS  > 1) ? clog2(NUM_WORDS)  : 1,
  localparam int unsigned BW = (WORD_BYTES > 1) ? clog2(WORD_BYTES) : 1,
  localparam int unsigned PW = clog2(NUM_WORDS * WORD_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_MEM_n,
  input  logic                    MEM_LOAD,
  input  logic [7:0]              MEM_IN,
  input  logic                    MEM_MODE,
  input  logic [AW-1:0]           MEM_WADDR,
  input  logic [BW-1:0]           MEM_LOAD_VAL,
  input  logic                    MEM_CLR,
  input  logic [AW-1:0]           MEM_RSEL,
  output logic [WORD_BYTES*8-1:0] MEM_OUT,
  output logic [PW-1:0]           MEM_PTR,
  output logic                    MEM_WORD_DONE,
  output logic                    MEM_FULL,
  output logic                    MEM_OVF
);

  localparam int unsigned TOTAL = NUM_WORDS * WORD_BYTES;

  logic [PW-1:0] ptr;
  logic [AW-1:0] s_word;
  logic [BW-1:0] s_lane;
  logic          full;
  logic          ovf;
  logic          word_done;

  logic          stream_req_c;
  logic          stream_wr_c;
  logic          addr_wr_c;
  logic          last_lane_c;
  logic          wr_en_c;
  logic [AW-1:0] wr_word_c;
  logic [BW-1:0] wr_lane_c;

  logic [WORD_BYTES-1:0]   we    [NUM_WORDS];
  logic [WORD_BYTES*8-1:0] words [NUM_WORDS];

  assign stream_req_c = MEM_LOAD && (MEM_MODE == MODE_STREAM) && !MEM_CLR;
  assign stream_wr_c  = stream_req_c && !full;
  assign addr_wr_c    = MEM_LOAD && (MEM_MODE == MODE_ADDR) && !MEM_CLR
                        && ({1'b0, MEM_WADDR}    < (AW+1)'(NUM_WORDS))
                        && ({1'b0, MEM_LOAD_VAL} < (BW+1)'(WORD_BYTES));
  assign last_lane_c  = (s_lane == BW'(WORD_BYTES - 1));

  // Word/lane pair tracks the pointer so no divider is needed on the write path.
  always_ff @(posedge clk or negedge rst_MEM_n) begin
    if (!rst_MEM_n) begin
      ptr       <= '0;
      s_word    <= '0;
      s_lane    <= '0;
      full      <= 1'b0;
      ovf       <= 1'b0;
      word_done <= 1'b0;
    end else if (MEM_CLR) begin
      ptr       <= '0;
      s_word    <= '0;
      s_lane    <= '0;
      full      <= 1'b0;
      ovf       <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= stream_wr_c && last_lane_c;
      if (stream_wr_c) begin
        ptr  <= ptr + PW'(1);
        full <= (ptr == PW'(TOTAL - 1));
        if (last_lane_c) begin
          s_lane <= '0;
          s_word <= s_word + AW'(1);
        end else begin
          s_lane <= s_lane + BW'(1);
        end
      end
      if (stream_req_c && full) ovf <= 1'b1;
    end
  end

  // Byte-lane write-enable decode for whichever mode owns the write.
  always_comb begin
    wr_en_c   = addr_wr_c;
    wr_word_c = MEM_WADDR;
    wr_lane_c = MEM_LOAD_VAL;
    if (MEM_MODE == MODE_STREAM) begin
      wr_en_c   = stream_wr_c;
      wr_word_c = s_word;
      wr_lane_c = s_lane;
    end
    for (int w = 0; w < int'(NUM_WORDS); w++) begin
      we[w] = '0;
      for (int l = 0; l < int'(WORD_BYTES); l++) begin
        if (wr_en_c && (wr_word_c == AW'(w)) && (wr_lane_c == BW'(l))) we[w][l] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_WORDS); g++) begin : g_word
    mem_byte_word #(
      .WORD_BYTES (WORD_BYTES)
    ) u_word (
      .clk   (clk),
      .rst_n (rst_MEM_n),
      .clr   (MEM_CLR),
      .we    (we[g]),
      .din   (MEM_IN),
      .q     (words[g])
    );
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    MEM_OUT = '0;
    for (int w = 0; w < int'(NUM_WORDS); w++) begin
      if (MEM_RSEL == AW'(w)) MEM_OUT = words[w];
    end
  end

  assign MEM_PTR       = ptr;
  assign MEM_WORD_DONE = word_done;
  assign MEM_FULL      = full;
  assign MEM_OVF       = ovf;

endmodule

// File: tb/tb_mem_word_bank.sv
// Directed bench for mem_word_bank: default 4x4 build plus a 3-word build on shared inputs.
module tb_mem_word_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        mode = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [1:0]  waddr = 2'd0;
  logic [1:0]  lane = 2'd0;
  logic [1:0]  rsel = 2'd0;

  logic [31:0] out_a, out_b;
  logic [4:0]  ptr_a;
  logic [3:0]  ptr_b;
  logic        done_a, full_a, ovf_a;
  logic        done_b, full_b, ovf_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_word_bank #(.WORD_BYTES(4), .NUM_WORDS(4)) dut_a (
    .clk           (clk),
    .rst_MEM_n     (rst_n),
    .MEM_LOAD      (load),
    .MEM_IN        (din),
    .MEM_MODE      (mode),
    .MEM_WADDR     (waddr),
    .MEM_LOAD_VAL  (lane),
    .MEM_CLR       (clr),
    .MEM_RSEL      (rsel),
    .MEM_OUT       (out_a),
    .MEM_PTR       (ptr_a),
    .MEM_WORD_DONE (done_a),
    .MEM_FULL      (full_a),
    .MEM_OVF       (ovf_a)
  );

  mem_word_bank #(.WORD_BYTES(4), .NUM_WORDS(3)) dut_b (
    .clk           (clk),
    .rst_MEM_n     (rst_n),
    .MEM_LOAD      (load),
    .MEM_IN        (din),
    .MEM_MODE      (mode),
    .MEM_WADDR     (waddr),
    .MEM_LOAD_VAL  (lane),
    .MEM_CLR       (clr),
    .MEM_RSEL      (rsel),
    .MEM_OUT       (out_b),
    .MEM_PTR       (ptr_b),
    .MEM_WORD_DONE (done_b),
    .MEM_FULL      (full_b),
    .MEM_OVF       (ovf_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one cycle of stimulus, return at the following falling edge.
  task automatic drive(input logic ld, input logic md, input logic [1:0] wa,
                       input logic [1:0] ln, input logic [7:0] d, input logic cl);
    load  = ld;
    mode  = md;
    waddr = wa;
    lane  = ln;
    din   = d;
    clr   = cl;
    @(negedge clk);
    load = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic read_a(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    rsel = sel;
    #1;
    check_eq(tag, out_a, exp);
  endtask

  task automatic read_b(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    rsel = sel;
    #1;
    check_eq(tag, out_b, exp);
  endtask

  initial begin
    // Reset state
    #1;
    check_eq("rst_ptr",  32'(ptr_a), 32'd0);
    check_eq("rst_full", 32'(full_a), 32'd0);
    check_eq("rst_ovf",  32'(ovf_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    read_a(2'd0, 32'h0, "rst_word0");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Addressed writes into word 2
    drive(1'b1, 1'b0, 2'd2, 2'd0, 8'hAA, 1'b0);
    drive(1'b1, 1'b0, 2'd2, 2'd1, 8'hFF, 1'b0);
    drive(1'b1, 1'b0, 2'd2, 2'd2, 8'hCC, 1'b0);
    drive(1'b1, 1'b0, 2'd2, 2'd3, 8'hDD, 1'b0);
    read_a(2'd2, 32'hDDCCFFAA, "addr_word2");
    read_a(2'd0, 32'h0, "addr_word0");
    read_a(2'd1, 32'h0, "addr_word1");
    read_a(2'd3, 32'h0, "addr_word3");
    check_eq("addr_ptr",  32'(ptr_a), 32'd0);
    check_eq("addr_done", 32'(done_a), 32'd0);

    // Stream 16 bytes back to back
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b1, 2'd0, 2'd0, 8'(i), 1'b0);
      check_eq($sformatf("strm_done_%0d", i), 32'(done_a), (i % 4 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("strm_ptr_%0d", i), 32'(ptr_a), 32'(i));
      check_eq($sformatf("strm_full_%0d", i), 32'(full_a), (i == 16) ? 32'd1 : 32'd0);
    end
    read_a(2'd0, 32'h04030201, "strm_word0");
    read_a(2'd1, 32'h08070605, "strm_word1");
    read_a(2'd2, 32'h0C0B0A09, "strm_word2");
    read_a(2'd3, 32'h100F0E0D, "strm_word3");

    // Write while full sets sticky overflow
    drive(1'b1, 1'b1, 2'd0, 2'd0, 8'hEE, 1'b0);
    check_eq("ovf_set",  32'(ovf_a), 32'd1);
    check_eq("ovf_ptr",  32'(ptr_a), 32'd16);
    check_eq("ovf_done", 32'(done_a), 32'd0);
    read_a(2'd3, 32'h100F0E0D, "ovf_word3");
    read_a(2'd0, 32'h04030201, "ovf_word0");
    drive(1'b0, 1'b1, 2'd0, 2'd0, 8'h00, 1'b0);
    check_eq("ovf_held", 32'(ovf_a), 32'd1);
    drive(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1);
    check_eq("clr_ptr",  32'(ptr_a), 32'd0);
    check_eq("clr_full", 32'(full_a), 32'd0);
    check_eq("clr_ovf",  32'(ovf_a), 32'd0);
    read_a(2'd0, 32'h0, "clr_word0");
    read_a(2'd3, 32'h0, "clr_word3");

    // Mode switch mid-word keeps the pointer
    drive(1'b1, 1'b1, 2'd0, 2'd0, 8'h11, 1'b0);
    drive(1'b1, 1'b1, 2'd0, 2'd0, 8'h22, 1'b0);
    check_eq("mix_ptr2", 32'(ptr_a), 32'd2);
    drive(1'b1, 1'b0, 2'd0, 2'd3, 8'h99, 1'b0);
    check_eq("mix_ptr_addr", 32'(ptr_a), 32'd2);
    check_eq("mix_done_addr", 32'(done_a), 32'd0);
    drive(1'b1, 1'b1, 2'd0, 2'd0, 8'h33, 1'b0);
    check_eq("mix_ptr3", 32'(ptr_a), 32'd3);
    check_eq("mix_done", 32'(done_a), 32'd0);
    read_a(2'd0, 32'h99332211, "mix_word0");

    // Clear wins over a simultaneous load
    drive(1'b1, 1'b1, 2'd0, 2'd0, 8'h44, 1'b1);
    check_eq("clrld_ptr", 32'(ptr_a), 32'd0);
    read_a(2'd0, 32'h0, "clrld_word0");
    drive(1'b1, 1'b0, 2'd1, 2'd0, 8'h77, 1'b1);
    read_a(2'd1, 32'h0, "clrld_word1");

    // Out-of-range word address on the 3-word build
    drive(1'b1, 1'b0, 2'd3, 2'd0, 8'h55, 1'b0);
    read_b(2'd3, 32'h0, "oor_b_rsel3");
    read_b(2'd0, 32'h0, "oor_b_word0");
    read_b(2'd1, 32'h0, "oor_b_word1");
    read_b(2'd2, 32'h0, "oor_b_word2");
    read_a(2'd3, 32'h00000055, "oor_a_word3");

    // Non-power-of-two capacity fills at 12 bytes
    drive(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1);
    for (int i = 1; i <= 12; i++) drive(1'b1, 1'b1, 2'd0, 2'd0, 8'(i), 1'b0);
    check_eq("b_full",  32'(full_b), 32'd1);
    check_eq("b_ptr",   32'(ptr_b), 32'd12);
    check_eq("b_done",  32'(done_b), 32'd1);
    check_eq("a_notfull", 32'(full_a), 32'd0);
    read_b(2'd2, 32'h0C0B0A09, "b_word2");
    drive(1'b1, 1'b1, 2'd0, 2'd0, 8'hEE, 1'b0);
    check_eq("b_ovf",   32'(ovf_b), 32'd1);
    check_eq("b_ptr_hold", 32'(ptr_b), 32'd12);
    check_eq("a_noovf", 32'(ovf_a), 32'd0);
    check_eq("a_ptr13", 32'(ptr_a), 32'd13);
    read_b(2'd0, 32'h04030201, "b_word0_kept");

    // Asynchronous reset between edges mid-stream
    drive(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1);
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b1, 2'd0, 2'd0, 8'(8'h40 + i), 1'b0);
    check_eq("pre_rst_done", 32'(done_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ptr",  32'(ptr_a), 32'd0);
    check_eq("arst_done", 32'(done_a), 32'd0);
    check_eq("arst_full", 32'(full_a), 32'd0);
    rsel = 2'd0;
    #0.1;
    check_eq("arst_word0", out_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
